// File: rtl/wb_mcu_debug_ctrl_pkg.sv
// Shared constants for the MCU debug/control front-end: register offsets,
// FSM state encodings and CTRL bit positions.
package mcu_dbg_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_STEP   = 3'd2;
  localparam logic [2:0] REG_BKPT   = 3'd3;
  localparam logic [2:0] REG_SNAP_R = 3'd4;
  localparam logic [2:0] REG_SNAP_O = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN    = 2'd0;
  localparam state_t ST_HALTED = 2'd1;
  localparam state_t ST_STEP   = 2'd2;

  localparam int unsigned CTRL_OVR      = 0;
  localparam int unsigned CTRL_RST      = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_CS_VAL   = 3;
  localparam int unsigned CTRL_BKPT_EN  = 4;
  localparam int unsigned CTRL_HALT_REQ = 5;
  localparam int unsigned CTRL_RESUME   = 6;
  localparam int unsigned CTRL_K_VAL    = 8;
  localparam int unsigned CTRL_K_MASK   = 12;
  localparam int unsigned STAT_BKPT_HIT = 2;
  localparam int unsigned SEL_BIT       = 23;

  // Storable CTRL bits; HALT_REQ/RESUME are pulses and K fields beyond kw are dropped.
  function automatic logic [15:0] ctrl_wmask(input int unsigned kw);
    logic [15:0] m;
    m = 16'h001F;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < kw) begin
        m[CTRL_K_VAL + i]  = 1'b1;
        m[CTRL_K_MASK + i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_mcu_debug_ctrl_if.sv
// Wishbone slave bundle between the bus fabric and the debug front-end.
interface wb_mcu_debug_ctrl_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport master (output adr, dat_w, we, cyc, stb, input dat_r, ack);
  modport slave  (input adr, dat_w, we, cyc, stb, output dat_r, ack);
endinterface

// File: rtl/wb_mcu_debug_ctrl_ack_delay.sv
// Wishbone acknowledge generator: accepts one transaction at a time and acks it
// ACK_LAT cycles later, dropping it silently if cyc is released first.
module wb_ack_delay #(
  parameter int unsigned ACK_LAT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic cyc_i,
  output logic accept_o,
  output logic ack_o
);
  logic       pend_q, pend_d;
  logic       ack_q, ack_d;
  logic [2:0] cnt_q, cnt_d;

  // The master still holds stb during the ack cycle, so that cycle never restarts.
  assign accept_o = valid_i & ~pend_q & ~ack_q;
  assign ack_o    = ack_q;

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    ack_d  = 1'b0;
    if (accept_o) begin
      if (ACK_LAT <= 1) begin
        ack_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        cnt_d  = 3'd1;
      end
    end else if (pend_q) begin
      if (!cyc_i) begin
        pend_d = 1'b0;
      end else if (cnt_q == 3'(ACK_LAT - 1)) begin
        pend_d = 1'b0;
        ack_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ack_q  <= ack_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/wb_mcu_debug_ctrl.sv
// Wishbone debug/control front-end for the 4-bit MCU cores: pin overrides,
// run/halt/N-step control, PC breakpoint and halt-time output snapshots.
module wb_mcu_debug_ctrl #(
  parameter int unsigned K_W     = 4,
  parameter int unsigned O_W     = 8,
  parameter int unsigned R_W     = 16,
  parameter int unsigned PC_W    = 11,
  parameter int unsigned STEP_W  = 16,
  parameter int unsigned ACK_LAT = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_mcu_debug_ctrl_if.slave wbs,
  input  logic [K_W-1:0]   pin_k_i,
  input  logic             pin_cs_i,
  output logic [K_W-1:0]   core_k_o,
  output logic             core_cs_o,
  input  logic [O_W-1:0]   core_o_i,
  input  logic [R_W-1:0]   core_r_i,
  input  logic [PC_W-1:0]  core_pc_i,
  input  logic             core_retire_i,
  output logic             core_en_o,
  output logic             core_rst_o,
  output logic             irq_o
);
  import mcu_dbg_pkg::*;

  localparam logic [15:0] CTRL_WMASK = ctrl_wmask(K_W);

  logic              valid, accept, wr, halt_req, resume, bp_hit, ovr_eff;
  logic [2:0]        sel;
  logic [31:0]       rdata;
  logic [15:0]       ctrl_q, ctrl_d;
  state_t            state_q, state_d;
  logic [STEP_W-1:0] steps_q, steps_d, step_n_q, step_n_d;
  logic [PC_W-1:0]   bkpt_q, bkpt_d;
  logic              hit_q, hit_d;
  logic [R_W-1:0]    snap_r_q;
  logic [O_W-1:0]    snap_o_q;
  logic [31:0]       dat_q;
  logic              unused_bus;

  assign valid      = wbs.cyc & wbs.stb & wbs.adr[SEL_BIT];
  assign sel        = wbs.adr[4:2];
  assign wr         = accept & wbs.we;
  assign wbs.dat_r  = dat_q;
  assign unused_bus = ^{wbs.adr, wbs.dat_w};

  wb_ack_delay #(.ACK_LAT(ACK_LAT)) u_ack (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .valid_i  (valid),
    .cyc_i    (wbs.cyc),
    .accept_o (accept),
    .ack_o    (wbs.ack)
  );

  assign core_en_o  = (state_q != ST_HALTED);
  assign core_rst_o = wb_rst_i | ctrl_q[CTRL_RST];
  assign irq_o      = hit_q & ctrl_q[CTRL_IRQ_EN];
  assign core_cs_o  = ctrl_q[CTRL_OVR] ? ctrl_q[CTRL_CS_VAL] : pin_cs_i;

  always_comb begin
    core_k_o = pin_k_i;
    for (int unsigned i = 0; i < K_W; i++) begin
      if (ctrl_q[CTRL_OVR] && ctrl_q[CTRL_K_MASK + i]) core_k_o[i] = ctrl_q[CTRL_K_VAL + i];
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    step_n_d = step_n_q;
    bkpt_d   = bkpt_q;
    state_d  = state_q;
    steps_d  = steps_q;
    hit_d    = hit_q;
    if (wr && sel == REG_CTRL) ctrl_d = wbs.dat_w[15:0] & CTRL_WMASK;
    if (wr && sel == REG_STEP) step_n_d = wbs.dat_w[STEP_W-1:0];
    if (wr && sel == REG_BKPT) bkpt_d = wbs.dat_w[PC_W-1:0];
    halt_req = wr && sel == REG_CTRL && wbs.dat_w[CTRL_HALT_REQ];
    resume   = wr && sel == REG_CTRL && wbs.dat_w[CTRL_RESUME];
    // A CTRL write that sets OVR together with HALT_REQ must halt immediately.
    ovr_eff  = ctrl_d[CTRL_OVR];
    bp_hit   = ovr_eff && ctrl_q[CTRL_BKPT_EN] && core_retire_i &&
               core_pc_i == bkpt_q && state_q != ST_HALTED;
    case (state_q)
      ST_RUN: if (halt_req || bp_hit) state_d = ST_HALTED;
      ST_HALTED: begin
        if (resume) begin
          state_d = ST_RUN;
        end else if (wr && sel == REG_STEP && wbs.dat_w[STEP_W-1:0] != '0) begin
          state_d = ST_STEP;
          steps_d = wbs.dat_w[STEP_W-1:0];
        end
      end
      ST_STEP: begin
        if (core_retire_i) steps_d = steps_q - STEP_W'(1);
        if (halt_req || bp_hit || (core_retire_i && steps_q == STEP_W'(1))) state_d = ST_HALTED;
      end
      default: state_d = ST_RUN;
    endcase
    if (!ovr_eff) state_d = ST_RUN;
    if (ctrl_q[CTRL_RST]) begin
      state_d = ST_RUN;
      steps_d = '0;
    end
    if (wr && sel == REG_STATUS && wbs.dat_w[STAT_BKPT_HIT]) hit_d = 1'b0;
    if (bp_hit) hit_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_CTRL:   rdata[15:0] = ctrl_q;
      REG_STATUS: begin
        rdata[1:0]           = state_q;
        rdata[STAT_BKPT_HIT] = hit_q;
        rdata[3]             = core_en_o;
        rdata[16 +: STEP_W]  = steps_q;
      end
      REG_STEP:   rdata[STEP_W-1:0] = step_n_q;
      REG_BKPT:   rdata[PC_W-1:0]   = bkpt_q;
      REG_SNAP_R: rdata[R_W-1:0]    = snap_r_q;
      REG_SNAP_O: begin
        rdata[O_W-1:0]   = snap_o_q;
        rdata[16 +: K_W] = core_k_o;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_q   <= '0;
      state_q  <= ST_RUN;
      steps_q  <= '0;
      step_n_q <= '0;
      bkpt_q   <= '0;
      hit_q    <= 1'b0;
      snap_r_q <= '0;
      snap_o_q <= '0;
      dat_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      state_q  <= state_d;
      steps_q  <= steps_d;
      step_n_q <= step_n_d;
      bkpt_q   <= bkpt_d;
      hit_q    <= hit_d;
      if (state_d == ST_HALTED && state_q != ST_HALTED) begin
        snap_r_q <= core_r_i;
        snap_o_q <= core_o_i;
      end
      if (accept) dat_q <= rdata;
    end
  end
endmodule

// File: tb/tb_wb_mcu_debug_ctrl.sv
// Scoreboard bench for wb_mcu_debug_ctrl: bus reads push expected data, the ack monitor pops and compares.
module tb_wb_mcu_debug_ctrl;
  localparam int unsigned ACK_LAT = 2;
  localparam logic [31:0] BASE    = 32'h0080_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pin_k, core_k;
  logic        pin_cs, core_cs;
  logic [7:0]  core_o;
  logic [15:0] core_r;
  logic [10:0] core_pc;
  logic        core_retire, core_en, core_rst, irq;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic        we;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  always #5 clk = ~clk;

  wb_mcu_debug_ctrl_if bus();

  wb_mcu_debug_ctrl #(
    .K_W(4), .O_W(8), .R_W(16), .PC_W(11), .STEP_W(16), .ACK_LAT(ACK_LAT)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs           (bus),
    .pin_k_i       (pin_k),
    .pin_cs_i      (pin_cs),
    .core_k_o      (core_k),
    .core_cs_o     (core_cs),
    .core_o_i      (core_o),
    .core_r_i      (core_r),
    .core_pc_i     (core_pc),
    .core_retire_i (core_retire),
    .core_en_o     (core_en),
    .core_rst_o    (core_rst),
    .irq_o         (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ack", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        if (!sb_e.we) chk(sb_e.tag, bus.dat_r, sb_e.exp);
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge following the ack.
  task automatic wb_xfer(input logic [2:0] r, input logic we, input logic [31:0] dat,
                         input logic [31:0] exp, input string tag);
    int lat;
    sb_q.push_back('{tag, we, exp});
    bus.adr   = BASE | {27'd0, r, 2'b00};
    bus.dat_w = dat;
    bus.we    = we;
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.ack !== 1'b1 && lat < 10);
    chk({tag, "_lat"}, lat, ACK_LAT);
    @(posedge clk); #1;
    chk({tag, "_ackw"}, {31'd0, bus.ack}, 32'd0);
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] r, input logic [31:0] dat, input string tag);
    wb_xfer(r, 1'b1, dat, 32'd0, tag);
  endtask

  task automatic rd(input logic [2:0] r, input logic [31:0] exp, input string tag);
    wb_xfer(r, 1'b0, 32'd0, exp, tag);
  endtask

  task automatic retire(input logic [10:0] pc);
    core_pc     = pc;
    core_retire = 1'b1;
    @(posedge clk); #1;
    core_retire = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    rst = 1'b1; pin_k = 4'h0; pin_cs = 1'b1; core_o = 8'h3C; core_r = 16'hBEEF;
    core_pc = '0; core_retire = 1'b0;
    bus.adr = '0; bus.dat_w = '0; bus.we = 1'b0; bus.cyc = 1'b0; bus.stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_core_en", {31'd0, core_en}, 32'd1);
    chk("rst_ack", {31'd0, bus.ack}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_dat", bus.dat_r, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_core_rst", {31'd0, core_rst}, 32'd0);

    rd(3'd0, 32'h0, "rst_ctrl");
    rd(3'd1, 32'h8, "rst_status");
    rd(3'd2, 32'h0, "rst_step");
    rd(3'd3, 32'h0, "rst_bkpt");
    rd(3'd4, 32'h0, "rst_snap_r");
    rd(3'd5, 32'h0, "rst_snap_o");
    wr(3'd6, 32'hFFFF_FFFF, "wr_reg6");
    rd(3'd6, 32'h0, "rd_reg6");
    rd(3'd1, 32'h8, "b2b_first");
    rd(3'd1, 32'h8, "b2b_second");

    bus.adr = BASE | 32'h4; bus.cyc = 1'b1; bus.stb = 1'b1;
    @(posedge clk); #1;
    bus.cyc = 1'b0; bus.stb = 1'b0;
    acc = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      acc |= bus.ack;
    end
    chk("cancel_noack", {31'd0, acc}, 32'd0);

    wr(3'd0, 32'h2, "ctrl_rst_set");
    chk("ctrl_rst_pin", {31'd0, core_rst}, 32'd1);
    rd(3'd0, 32'h2, "ctrl_rst_rd");
    wr(3'd0, 32'h0, "ctrl_rst_clr");
    chk("ctrl_rst_off", {31'd0, core_rst}, 32'd0);

    wr(3'd0, 32'h21, "halt");
    chk("halt_en", {31'd0, core_en}, 32'd0);
    core_r = 16'h1234;
    rd(3'd4, 32'hBEEF, "halt_snap_r");
    rd(3'd0, 32'h01, "halt_ctrl");
    rd(3'd1, 32'h1, "halt_status");
    wr(3'd2, 32'd3, "step3");
    rd(3'd2, 32'd3, "step3_rd");
    rd(3'd1, 32'h0003_000A, "step3_status");
    for (int i = 0; i < 3; i++) begin
      chk("step_en", {31'd0, core_en}, 32'd1);
      retire(11'h010 + 11'(i));
    end
    chk("step_done_en", {31'd0, core_en}, 32'd0);
    rd(3'd1, 32'h1, "step_done_status");
    rd(3'd4, 32'h1234, "step_done_snap_r");

    wr(3'd3, 32'h1A5, "bkpt_set");
    rd(3'd3, 32'h1A5, "bkpt_rd");
    wr(3'd0, 32'h55, "bkpt_resume");
    chk("bkpt_run_en", {31'd0, core_en}, 32'd1);
    retire(11'h100);
    chk("bkpt_miss_en", {31'd0, core_en}, 32'd1);
    retire(11'h1A5);
    chk("bkpt_hit_en", {31'd0, core_en}, 32'd0);
    chk("bkpt_irq", {31'd0, irq}, 32'd1);
    rd(3'd1, 32'h5, "bkpt_status");
    rd(3'd0, 32'h15, "bkpt_ctrl");
    wr(3'd1, 32'h4, "bkpt_w1c");
    chk("bkpt_irq_clr", {31'd0, irq}, 32'd0);
    rd(3'd1, 32'h1, "bkpt_status_clr");

    pin_k = 4'h0;
    wr(3'd0, 32'h5F01, "kovr");
    chk("kovr_k", {28'd0, core_k}, 32'h5);
    chk("kovr_cs", {31'd0, core_cs}, 32'd0);
    rd(3'd5, 32'h0005_003C, "kovr_snap_o");
    pin_k = 4'hA;
    #1;
    chk("kovr_k_mix", {28'd0, core_k}, 32'hF);
    wr(3'd0, 32'h0, "kovr_off");
    chk("kovr_off_k", {28'd0, core_k}, 32'hA);
    chk("kovr_off_cs", {31'd0, core_cs}, 32'd1);
    chk("kovr_off_en", {31'd0, core_en}, 32'd1);
    pin_k = 4'h0;

    wr(3'd0, 32'h21, "e_halt");
    wr(3'd2, 32'd0, "e_step0");
    chk("e_step0_en", {31'd0, core_en}, 32'd0);
    rd(3'd1, 32'h1, "e_step0_status");
    rd(3'd2, 32'd0, "e_step0_rd");
    wr(3'd0, 32'h41, "e_resume");
    chk("e_resume_en", {31'd0, core_en}, 32'd1);
    wr(3'd2, 32'd5, "e_step_run");
    rd(3'd1, 32'h8, "e_step_run_status");
    rd(3'd2, 32'd5, "e_step_run_rd");
    wr(3'd0, 32'h21, "e_halt2");
    wr(3'd2, 32'd4, "e_step4");
    retire(11'h020);
    retire(11'h021);
    rd(3'd1, 32'h0002_000A, "e_step_rem2");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("e_rst_en", {31'd0, core_en}, 32'd1);
    rd(3'd1, 32'h8, "e_rst_status");
    rd(3'd0, 32'h0, "e_rst_ctrl");
    rd(3'd2, 32'h0, "e_rst_step");

    wr(3'd0, 32'h21, "h_halt");
    wr(3'd2, 32'd3, "h_step3");
    retire(11'h030);
    wr(3'd0, 32'h21, "h_halt_in_step");
    chk("h_en", {31'd0, core_en}, 32'd0);
    rd(3'd1, 32'h0002_0001, "h_status");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
